peribus_master: RTL and testbench
=================================

PERIBUS_MASTER -- requirements
Module: peribus_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 12'hFFF: value that cpu_addr[15:4] must match for a Peribus access.
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port cpu_req, input, 1: CPU access request, held high until cpu_ready.
REQ-005 SHALL have port cpu_we, input, 1: 1 = write, 0 = read.
REQ-006 SHALL have port cpu_addr, input, 16: [15:4] base match, [3:2] peripheral select, [1:0] register.
REQ-007 SHALL have port cpu_wdata, input, 16: write data.
REQ-008 SHALL have port cpu_ready, output, 1: one-cycle completion pulse.
REQ-009 SHALL have port cpu_err, output, 1: valid with cpu_ready; 1 = base mismatch.
REQ-010 SHALL have port cpu_rdata, output, 16: read result, held until the next successful read.
REQ-011 SHALL have port pb_addr, output, 2: Peribus register address.
REQ-012 SHALL have port pb_write_data, output, 16: Peribus write data.
REQ-013 SHALL have ports pb_write_en and pb_read_en, output, 1 each: Peribus strobes.
REQ-014 SHALL have port pb_chipselect, output, 4: one-hot peripheral select.
REQ-015 SHALL have port pb_read_data, input, 64: slot n occupies bits [16n+15:16n].
REQ-016 SHALL have port pb_irq, input, 4: per-peripheral interrupt lines.
REQ-017 SHALL have port cpu_irq, output, 1: OR of pending peripheral interrupts.
REQ-018 SHALL have port irq_id, output, 2: lowest-numbered pending interrupt slot.

Function
REQ-019 SHALL implement states IDLE, ACCESS, CAPTURE, DONE, ERR.
REQ-020 IDLE: when cpu_req=1, SHALL latch cpu_we, cpu_addr and cpu_wdata; next state is ACCESS on base match, otherwise ERR.
REQ-021 ACCESS (exactly one cycle): pb_chipselect SHALL be one-hot per latched addr[3:2].
REQ-022 ACCESS: pb_addr SHALL equal latched addr[1:0] and pb_write_data SHALL equal latched wdata.
REQ-023 ACCESS: exactly one of pb_write_en/pb_read_en SHALL be 1, per latched we; next state is DONE for a write, CAPTURE for a read.
REQ-024 Outside ACCESS, pb_chipselect, pb_write_en and pb_read_en SHALL be 0; pb_addr and pb_write_data hold their last value.
REQ-025 CAPTURE SHALL register the selected pb_read_data slot into cpu_rdata (peripheral read data is valid the cycle after the read strobe), then go to DONE.
REQ-026 DONE SHALL assert cpu_ready=1 with cpu_err=0 for one cycle, then return to IDLE.
REQ-027 ERR SHALL assert cpu_ready=1 with cpu_err=1 for one cycle, issue no bus strobes, leave cpu_rdata unchanged, then return to IDLE.
REQ-028 cpu_req SHALL be sampled only in IDLE; a request held through DONE/ERR is re-accepted in the following IDLE cycle.
REQ-029 Latency from request acceptance to cpu_ready SHALL be: write 2 cycles, read 3 cycles, error 1 cycle.
REQ-030 cpu_irq SHALL equal the registered |pb_irq (one-cycle latency).
REQ-031 irq_id SHALL equal the registered index of the lowest set pb_irq bit, and 0 when none is set.

Reset
REQ-032 When reset_n=0 at a rising edge, state SHALL become IDLE and every output SHALL become 0 (cpu_rdata=16'h0, pb_chipselect=4'h0, cpu_irq=0, irq_id=0).
REQ-033 Reset asserted mid-transaction SHALL abort it without a cpu_ready pulse; strobes SHALL be low from the first cycle after the reset edge.

Verification
REQ-034 Write: req, we=1, addr=16'hFFF6, wdata=16'hA5A5 -> next cycle cs=4'b0010, addr=2'd2, write_en=1, wdata=16'hA5A5; cpu_ready=1, err=0 one cycle later.
REQ-035 Read: req, we=0, addr=16'hFFFD, slot 3 returns 16'h1234 the cycle after read_en -> cs=4'b1000, read_en=1; cpu_rdata=16'h1234 with cpu_ready 3 cycles after acceptance.
REQ-036 Error: req, addr=16'h0004 -> cpu_ready=1, cpu_err=1 after 1 cycle; no strobes; cpu_rdata unchanged.
REQ-037 Back-to-back: cpu_req held high across two reads -> second acceptance in the IDLE cycle after DONE; strobes never asserted in consecutive cycles.
REQ-038 IRQ: pb_irq=4'b1100 -> next cycle cpu_irq=1, irq_id=2; pb_irq=0 -> next cycle cpu_irq=0, irq_id=0.
REQ-039 Reset in ACCESS: reset_n=0 during a read -> no cpu_ready pulse, outputs 0 next cycle, a new request after reset completes normally.

Source files
------------

// File: rtl/peribus_master.sv
// peribus_master: CPU-to-Peribus bridge with a one-shot access FSM and registered
// interrupt summary (OR of lines plus lowest pending slot).
module peribus_master #(
  parameter logic [11:0] BASE_ADDR = 12'hFFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  output logic [15:0] cpu_rdata,
  output logic [1:0]  pb_addr,
  output logic [15:0] pb_write_data,
  output logic        pb_write_en,
  output logic        pb_read_en,
  output logic [3:0]  pb_chipselect,
  input  logic [63:0] pb_read_data,
  input  logic [3:0]  pb_irq,
  output logic        cpu_irq,
  output logic [1:0]  irq_id
);
  typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, DONE, ERR} state_t;
  state_t      r_state, w_next;
  logic        r_we;
  logic [3:0]  r_addr;
  logic [15:0] r_wdata, r_rdata;
  logic        r_irq;
  logic [1:0]  r_irq_id, w_irq_id;
  logic        w_match, w_accept;
  assign w_match  = cpu_addr[15:4] == BASE_ADDR;
  assign w_accept = r_state == IDLE && cpu_req;
  assign w_irq_id = pb_irq[0] ? 2'd0 : pb_irq[1] ? 2'd1 : pb_irq[2] ? 2'd2 : pb_irq[3] ? 2'd3 : 2'd0;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_addr   <= 4'h0;
      r_wdata  <= 16'h0;
      r_rdata  <= 16'h0;
      r_irq    <= 1'b0;
      r_irq_id <= 2'd0;
    end else begin
      r_state  <= w_next;
      // Mismatched requests are not latched so pb_addr/pb_write_data keep the last real access.
      if (w_accept && w_match) begin
        r_we    <= cpu_we;
        r_addr  <= cpu_addr[3:0];
        r_wdata <= cpu_wdata;
      end
      if (r_state == CAPTURE) r_rdata <= pb_read_data[{r_addr[3:2], 4'b0000} +: 16];
      r_irq    <= |pb_irq;
      r_irq_id <= w_irq_id;
    end
  end
  always_comb begin
    w_next        = r_state;
    cpu_ready     = 1'b0;
    cpu_err       = 1'b0;
    pb_write_en   = 1'b0;
    pb_read_en    = 1'b0;
    pb_chipselect = 4'h0;
    case (r_state)
      IDLE:    w_next = cpu_req ? (w_match ? ACCESS : ERR) : IDLE;
      ACCESS: begin
        w_next        = r_we ? DONE : CAPTURE;
        pb_write_en   = r_we;
        pb_read_en    = !r_we;
        pb_chipselect = 4'b0001 << r_addr[3:2];
      end
      CAPTURE: w_next = DONE;
      DONE: begin
        w_next    = IDLE;
        cpu_ready = 1'b1;
      end
      default: begin
        w_next    = IDLE;
        cpu_ready = 1'b1;
        cpu_err   = 1'b1;
      end
    endcase
  end
  assign pb_addr       = r_addr[1:0];
  assign pb_write_data = r_wdata;
  assign cpu_rdata     = r_rdata;
  assign cpu_irq       = r_irq;
  assign irq_id        = r_irq_id;
endmodule

// File: tb/tb_peribus_master.sv
// tb_peribus_master: table-driven transactions plus hand-written back-to-back,
// interrupt and mid-access reset sequences.
module tb_peribus_master;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_ready, cpu_err;
  logic [15:0] cpu_rdata;
  logic [1:0]  pb_addr;
  logic [15:0] pb_write_data;
  logic        pb_write_en, pb_read_en;
  logic [3:0]  pb_chipselect;
  logic [63:0] pb_read_data;
  logic [3:0]  pb_irq;
  logic        cpu_irq;
  logic [1:0]  irq_id;
  int          errors = 0, checks = 0, consec = 0;
  logic [15:0] rd_val = 16'h0;
  logic        prev_strobe = 1'b0;
  logic [1:0]  last_pa = 2'd0;
  logic [15:0] last_wd = 16'h0;
  peribus_master dut (
    .clock(clock), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata), .pb_addr(pb_addr), .pb_write_data(pb_write_data),
    .pb_write_en(pb_write_en), .pb_read_en(pb_read_en), .pb_chipselect(pb_chipselect),
    .pb_read_data(pb_read_data), .pb_irq(pb_irq), .cpu_irq(cpu_irq), .irq_id(irq_id)
  );
  always #5 clock = ~clock;
  // Peripheral model: selected slot returns rd_val only in the cycle after the read strobe.
  always @(posedge clock)
    for (int k = 0; k < 4; k++)
      pb_read_data[16*k +: 16] <= (pb_read_en && pb_chipselect[k]) ? rd_val : 16'hEE00 + 16'(k);
  always @(negedge clock) begin
    if ((pb_write_en || pb_read_en) && prev_strobe) consec++;
    prev_strobe <= pb_write_en || pb_read_en;
  end
  typedef struct {
    logic        we;
    logic [15:0] addr, wdata, rd;
    logic [3:0]  cs;
    logic [1:0]  pa;
    int          lat;
    logic        err;
    logic [15:0] rdata;
  } vec_t;
  vec_t vt[7];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run(input int i);
    int lat;
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = vt[i].we; cpu_addr = vt[i].addr; cpu_wdata = vt[i].wdata; rd_val = vt[i].rd;
    @(negedge clock);
    lat = 1;
    if (vt[i].err) begin
      chk($sformatf("v%0d_err_strobes", i), {pb_chipselect, pb_write_en, pb_read_en}, 6'h0);
      chk($sformatf("v%0d_err_hold", i), {pb_addr, pb_write_data}, {last_pa, last_wd});
    end else begin
      chk($sformatf("v%0d_cs", i), pb_chipselect, vt[i].cs);
      chk($sformatf("v%0d_pa_wd", i), {pb_addr, pb_write_data}, {vt[i].pa, vt[i].wdata});
      chk($sformatf("v%0d_we_re", i), {pb_write_en, pb_read_en}, {vt[i].we, !vt[i].we});
      last_pa = vt[i].pa;
      last_wd = vt[i].wdata;
    end
    while (!cpu_ready && lat < 8) begin
      @(negedge clock);
      lat++;
    end
    chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
    chk($sformatf("v%0d_err", i), cpu_err, vt[i].err);
    chk($sformatf("v%0d_rdata", i), cpu_rdata, vt[i].rdata);
    cpu_req = 1'b0;
  endtask
  initial begin
    vt[0] = '{1'b1, 16'hFFF6, 16'hA5A5, 16'h0000, 4'b0010, 2'd2, 2, 1'b0, 16'h0000};
    vt[1] = '{1'b0, 16'hFFFD, 16'h0000, 16'h1234, 4'b1000, 2'd1, 3, 1'b0, 16'h1234};
    vt[2] = '{1'b0, 16'h0004, 16'h7777, 16'h9999, 4'b0000, 2'd0, 1, 1'b1, 16'h1234};
    vt[3] = '{1'b0, 16'hFFF0, 16'h1111, 16'h0BEE, 4'b0001, 2'd0, 3, 1'b0, 16'h0BEE};
    vt[4] = '{1'b1, 16'hFFFB, 16'h5A5A, 16'h0000, 4'b0100, 2'd3, 2, 1'b0, 16'h0BEE};
    vt[5] = '{1'b1, 16'hFFE5, 16'h3333, 16'h0000, 4'b0000, 2'd0, 1, 1'b1, 16'h0BEE};
    vt[6] = '{1'b0, 16'hFFF6, 16'h0000, 16'hCAFE, 4'b0010, 2'd2, 3, 1'b0, 16'hCAFE};
    reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0; pb_irq = 4'h0;
    repeat (2) @(negedge clock);
    chk("reset_ctl", {cpu_ready, cpu_err, pb_write_en, pb_read_en, pb_chipselect}, 8'h0);
    chk("reset_data", {cpu_rdata, pb_write_data, pb_addr, cpu_irq, irq_id}, 37'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) run(i);
    // Back-to-back reads with cpu_req held high throughout.
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFFF1; rd_val = 16'h1111;
    repeat (3) @(negedge clock);
    chk("b2b_ready1", {cpu_ready, cpu_rdata}, {1'b1, 16'h1111});
    rd_val = 16'h2222;
    @(negedge clock);
    chk("b2b_idle", {cpu_ready, pb_read_en}, 2'b00);
    @(negedge clock);
    chk("b2b_access2", {pb_read_en, pb_chipselect}, {1'b1, 4'b0001});
    repeat (2) @(negedge clock);
    chk("b2b_ready2", {cpu_ready, cpu_rdata}, {1'b1, 16'h2222});
    cpu_req = 1'b0;
    // Interrupt summary.
    pb_irq = 4'b1100;
    @(negedge clock);
    chk("irq_1100", {cpu_irq, irq_id}, {1'b1, 2'd2});
    pb_irq = 4'b1010;
    @(negedge clock);
    chk("irq_1010", {cpu_irq, irq_id}, {1'b1, 2'd1});
    pb_irq = 4'b1001;
    @(negedge clock);
    chk("irq_1001", {cpu_irq, irq_id}, {1'b1, 2'd0});
    pb_irq = 4'b0000;
    @(negedge clock);
    chk("irq_none", {cpu_irq, irq_id}, {1'b0, 2'd0});
    // Reset during the ACCESS cycle of a read.
    pb_irq = 4'b0100;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFFFE; rd_val = 16'hBEEF;
    @(negedge clock);
    chk("rst_access", pb_read_en, 1'b1);
    reset_n = 1'b0; cpu_req = 1'b0;
    @(negedge clock);
    chk("rst_ctl", {cpu_ready, pb_write_en, pb_read_en, pb_chipselect}, 7'h0);
    chk("rst_data", {cpu_rdata, pb_addr, cpu_irq, irq_id}, 21'h0);
    reset_n = 1'b1; pb_irq = 4'h0;
    repeat (2) begin
      @(negedge clock);
      chk("rst_no_ready", cpu_ready, 1'b0);
    end
    last_pa = 2'd0; last_wd = 16'h0;
    run(3);
    chk("no_consec_strobes", consec, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
